time_mux_capture: RTL
=====================

# time_mux_capture

Receive-side counterpart of the four-digit time-multiplexed seven-segment driver. Samples the multiplexed anode/segment bus and demultiplexes it back into four per-digit segment registers, then decodes each digit to a hex nibble. A stability filter ignores transient or glitch values, and the block flags frames and illegal anode patterns. It sits on the display bus in self-test and loopback builds, and lets the bench check the display path end-to-end.

## Interface
- STABLE_CYCLES, 1: consecutive samples an {an, sseg} value must hold before capture; legal range 1..255.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- an_in  input  4  anode bus, active-low, one digit per bit (bit0 = digit0).
- sseg_in  input  7  segment bus, active-low, bit0 = a … bit6 = g.
- seg0..seg3  output  7 each  last captured segment pattern per digit.
- hex  output  16  decoded digits, {hex3, hex2, hex1, hex0}, 4 bits each.
- hex_valid  output  4  bit k = 1 when seg_k matches a legal hex glyph.
- frame_done  output  1  one-cycle pulse when all four digits have been captured since the last pulse.
- err_multi  output  1  one-cycle pulse when a stable sample has more than one anode active.

## Operation
- Inputs are synchronous to clk. There is no synchronizer. {an_in, sseg_in} is registered once into a sample register.
- Stability counter: 8-bit, saturating.
  - Clears when the new sample differs from the held sample.
  - Increments otherwise.
  - A "stable event" fires exactly once per run, on the cycle the run length reaches STABLE_CYCLES.
  - No re-fire until the value changes.
- Anode classification at a stable event:
  - Exactly one zero bit at index k: capture digit k.
  - 4'b1111 (idle/blank): no action.
  - Any other value: err_multi pulse, no capture.
- Capture of digit k:
  - seg_k <= sample sseg.
  - hex nibble k <= decoded value.
  - hex_valid[k] <= match.
  - seen[k] <= 1.
- Decode table (active-low, g..a), values 0-F: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E.
  - Any other pattern: hex nibble = 0, hex_valid bit = 0, seg_k still updated.
- Frame tracking:
  - seen is a 4-bit internal mask. Capture order is irrelevant.
  - If a capture makes seen == 4'b1111, frame_done pulses on the same edge the capture registers update, and seen clears to 0000.
  - Re-capturing an already-seen digit overwrites its data and does not affect frame_done.
- Reset values (asserted reset, asynchronous):
  - seg0..seg3 = 7'h7F.
  - hex = 16'h0000, hex_valid = 4'b0000.
  - frame_done = 0, err_multi = 0.
  - seen = 0000.
  - Sample register = {4'hF, 7'h7F}, stability counter = 0.
- Reset mid-frame discards partial-frame progress (seen cleared). Reset release is ordinary; the first edge after release samples normally.

## Timing
- A value first sampled on edge t produces its capture/error effects on the outputs at edge t + STABLE_CYCLES.
- STABLE_CYCLES = 1 tracks a driver that rotates every clock. Each digit is captured one edge after sampling.
- A value held for fewer than STABLE_CYCLES samples is never captured and raises no error.
- frame_done and err_multi are high for exactly one cycle per event. They never assert simultaneously, because an event is either a capture or an error.
- Back-to-back stable events on consecutive cycles are legal with no dead cycle.
- The counter saturates at 255. An arbitrarily long hold produces no further events.

## Test plan
- STABLE_CYCLES=1, driver rotating every cycle (digit0..3 = glyphs 1,2,3,4 = 79, 24, 30, 19) → after 4 captures, hex = 16'h4321 and hex_valid = 1111. frame_done pulses once every 4 cycles, err_multi stays 0.
- STABLE_CYCLES=3:
  - an=1011, sseg=12 held 2 cycles, then an=1111 → seg2 stays 7F, no pulse.
  - Same value held 3 cycles → seg2 = 12 and hex[11:8] = 5 at edge t+3, captured once only.
- an=1100 held stable → err_multi high exactly one cycle, all seg/hex outputs unchanged, seen unchanged.
- Digit0 pattern 7F (blank), then 7A (non-glyph) → seg0 = 7F then 7A, hex_valid[0] = 0, hex[3:0] = 0, and digit0 still counts toward frame_done.
- Capture digits 0 and 1, pulse reset low for one cycle mid-stream, then capture digits 2 and 3 → all outputs at reset values after reset, and no frame_done until digits 0 and 1 are captured again.
- Capture digit0 five times, then digits 1, 2, 3 once each → frame_done pulses exactly once, on the digit3 capture edge. seg0 holds the last written value.

Source files
------------

// File: rtl/time_mux_capture.sv
// Demultiplexes a time-multiplexed 4-digit seven-segment bus back into per-digit
// segment registers and hex nibbles, gated by a run-length stability filter.

module time_mux_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic       cap,
  input  logic [6:0] sseg,
  input  logic [3:0] nib,
  input  logic       vld,
  output logic [6:0] seg,
  output logic [3:0] hex,
  output logic       hex_valid
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg       <= 7'h7F;
      hex       <= 4'h0;
      hex_valid <= 1'b0;
    end else if (cap) begin
      seg       <= sseg;
      hex       <= nib;
      hex_valid <= vld;
    end
  end
endmodule

module time_mux_capture #(
  parameter int STABLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an_in,
  input  logic [6:0]  sseg_in,
  output logic [6:0]  seg0,
  output logic [6:0]  seg1,
  output logic [6:0]  seg2,
  output logic [6:0]  seg3,
  output logic [15:0] hex,
  output logic [3:0]  hex_valid,
  output logic        frame_done,
  output logic        err_multi
);
  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

  logic [3:0]      s_an;
  logic [6:0]      s_seg;
  logic [7:0]      cnt;
  logic            ev;
  logic [3:0]      sel;
  logic            err_ev;
  logic [3:0]      cap;
  logic [3:0]      seen;
  logic [3:0]      seen_nxt;
  logic            frame_ev;
  logic [3:0]      nib;
  logic            vld;
  logic [3:0][6:0] seg_q;

  // cnt is run length minus one, so the event fires on the cycle the held
  // sample has been seen STABLE_CYCLES times; saturation at 255 blocks re-fire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_an  <= 4'hF;
      s_seg <= 7'h7F;
      cnt   <= 8'd0;
    end else begin
      s_an  <= an_in;
      s_seg <= sseg_in;
      if ({an_in, sseg_in} != {s_an, s_seg}) cnt <= 8'd0;
      else if (cnt != 8'hFF)                 cnt <= cnt + 8'd1;
    end
  end

  assign ev = (cnt == LAST);

  always_comb begin
    sel = 4'b0000;
    case (s_an)
      4'b1110: sel = 4'b0001;
      4'b1101: sel = 4'b0010;
      4'b1011: sel = 4'b0100;
      4'b0111: sel = 4'b1000;
      default: sel = 4'b0000;
    endcase
  end

  assign cap    = ev ? sel : 4'b0000;
  assign err_ev = ev && (sel == 4'b0000) && (s_an != 4'hF);

  always_comb begin
    nib = 4'h0;
    vld = 1'b1;
    case (s_seg)
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: begin
        nib = 4'h0;
        vld = 1'b0;
      end
    endcase
  end

  assign seen_nxt = seen | cap;
  assign frame_ev = (cap != 4'b0000) && (seen_nxt == 4'hF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen       <= 4'b0000;
      frame_done <= 1'b0;
      err_multi  <= 1'b0;
    end else begin
      seen       <= frame_ev ? 4'b0000 : seen_nxt;
      frame_done <= frame_ev;
      err_multi  <= err_ev;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_dig
    time_mux_digit u_dig (
      .clk       (clk),
      .reset     (reset),
      .cap       (cap[k]),
      .sseg      (s_seg),
      .nib       (nib),
      .vld       (vld),
      .seg       (seg_q[k]),
      .hex       (hex[4*k +: 4]),
      .hex_valid (hex_valid[k])
    );
  end

  assign seg0 = seg_q[0];
  assign seg1 = seg_q[1];
  assign seg2 = seg_q[2];
  assign seg3 = seg_q[3];
endmodule
